// File: rtl/dsp_config_loader.sv
// Serial loader for a DSP configuration chain.
// Fetches words over valid/ready and shifts them LSB-first into the chain.
module dsp_config_loader #(
  parameter int CHAIN_LENGTH = 100,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  RSTN,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_word,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  configuration_input,
  output logic                  configuration_enable,
  output logic                  busy,
  output logic                  done,
  output logic [11:0]           bit_count
);

  localparam int WBW =
    (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam logic [11:0] LAST_BIT =
    12'(CHAIN_LENGTH - 1);
  localparam logic [WBW-1:0] LAST_WBIT =
    WBW'(WORD_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_WIDTH-1:0] sr_q, sr_d;
  logic                  cin_q, cin_d;
  logic                  en_q, en_d;
  logic [11:0]           cnt_q, cnt_d;
  logic [WBW-1:0]        wbit_q, wbit_d;

  // State and datapath registers; serial outputs come straight from flops
  always_ff @(posedge clk) begin
    if (!RSTN) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cin_q   <= 1'b0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
      wbit_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cin_q   <= cin_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
      wbit_q  <= wbit_d;
    end
  end

  // Next state: the chain-complete test wins over word exhaustion
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cin_d   = 1'b0;
    en_d    = 1'b0;
    cnt_d   = cnt_q;
    wbit_d  = wbit_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          cnt_d   = '0;
          wbit_d  = '0;
        end
      end
      FETCH: begin
        if (cfg_valid) begin
          state_d = SHIFT;
          cin_d   = cfg_word[0];
          sr_d    = cfg_word >> 1;
          en_d    = 1'b1;
          wbit_d  = '0;
        end
      end
      SHIFT: begin
        cnt_d  = cnt_q + 12'd1;
        wbit_d = wbit_q + WBW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end else if (wbit_q == LAST_WBIT) begin
          state_d = FETCH;
        end else begin
          cin_d = sr_q[0];
          sr_d  = sr_q >> 1;
          en_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign cfg_ready            = (state_q == FETCH);
  assign busy                 = (state_q == FETCH)
                              | (state_q == SHIFT);
  assign done                 = (state_q == DONE);
  assign configuration_input  = cin_q;
  assign configuration_enable = en_q;
  assign bit_count            = cnt_q;

endmodule
